// File: rtl/pipeline_arbiter.sv
// Round-robin issue of NUM_REQ requesters into one fixed-latency CORDIC pipeline; results are tag-steered
// into credited per-requester show-ahead FIFOs. Define ARB_PERF_CNT_EN to add perf_busy/perf_stall counters.
module pipeline_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int PIPE_LATENCY = 8,
    parameter int RSP_DEPTH    = 2,
    parameter int TAG_WIDTH    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]  req_x,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]  req_y,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]  req_z,
    output logic                            pipe_in_valid,
    output logic [INPUT_WIDTH-1:0]          pipe_x,
    output logic [INPUT_WIDTH-1:0]          pipe_y,
    output logic [INPUT_WIDTH-1:0]          pipe_z,
    input  logic                            pipe_out_valid,
    input  logic [OUTPUT_WIDTH-1:0]         pipe_out_x,
    input  logic [OUTPUT_WIDTH-1:0]         pipe_out_y,
    input  logic [OUTPUT_WIDTH-1:0]         pipe_out_z,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [NUM_REQ*OUTPUT_WIDTH-1:0] rsp_x,
    output logic [NUM_REQ*OUTPUT_WIDTH-1:0] rsp_y,
    output logic [NUM_REQ*OUTPUT_WIDTH-1:0] rsp_z,
    output logic                            tag_err
`ifdef ARB_PERF_CNT_EN
    ,
    input  logic                            perf_clr,
    output logic [31:0]                     perf_busy,
    output logic [31:0]                     perf_stall
`endif
);

    localparam int CRED_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int DATA_W = 3 * OUTPUT_WIDTH;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic                 grant_any;
    logic [TAG_WIDTH-1:0] winner;
    logic [TAG_WIDTH-1:0] ptr_reg;

    logic [PIPE_LATENCY:0] tag_v_reg;
    logic [TAG_WIDTH-1:0]  tag_id_reg [PIPE_LATENCY+1];
    logic                  tag_end_v;
    logic [TAG_WIDTH-1:0]  tag_end_id;

    // First eligible requester searching upward from ptr+1 with wrap.
    always_comb begin : arb_sel
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        winner    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_reg) + k) % NUM_REQ;
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                winner    = TAG_WIDTH'(idx);
            end
        end
        if (grant_any) begin
            grant[winner] = 1'b1;
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_in_valid <= 1'b0;
            pipe_x        <= '0;
            pipe_y        <= '0;
            pipe_z        <= '0;
            ptr_reg       <= TAG_WIDTH'(NUM_REQ - 1);
        end else begin
            pipe_in_valid <= grant_any;
            if (grant_any) begin
                pipe_x  <= req_x[int'(winner)*INPUT_WIDTH +: INPUT_WIDTH];
                pipe_y  <= req_y[int'(winner)*INPUT_WIDTH +: INPUT_WIDTH];
                pipe_z  <= req_z[int'(winner)*INPUT_WIDTH +: INPUT_WIDTH];
                ptr_reg <= winner;
            end
        end
    end

    // Stage 0 loads with the issue register, so the last stage lines up with pipe_out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_reg <= '0;
            for (int s = 0; s <= PIPE_LATENCY; s++) begin
                tag_id_reg[s] <= '0;
            end
        end else begin
            tag_v_reg     <= {tag_v_reg[PIPE_LATENCY-1:0], grant_any};
            tag_id_reg[0] <= winner;
            for (int s = 1; s <= PIPE_LATENCY; s++) begin
                tag_id_reg[s] <= tag_id_reg[s-1];
            end
        end
    end

    assign tag_end_v  = tag_v_reg[PIPE_LATENCY];
    assign tag_end_id = tag_id_reg[PIPE_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_err <= 1'b0;
        end else if (pipe_out_valid != tag_end_v) begin
            tag_err <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [CRED_W-1:0] credit_reg;
        logic [CRED_W-1:0] count_reg;
        logic [PTR_W-1:0]  wr_ptr_reg;
        logic [PTR_W-1:0]  rd_ptr_reg;
        logic [DATA_W-1:0] mem [RSP_DEPTH];
        logic [DATA_W-1:0] head;
        logic              push;
        logic              pop;

        assign eligible[gi]  = req_valid[gi] && (credit_reg != '0);
        assign push          = pipe_out_valid && tag_end_v && (tag_end_id == TAG_WIDTH'(gi));
        assign rsp_valid[gi] = (count_reg != '0);
        assign pop           = rsp_valid[gi] && rsp_ready[gi];
        assign head          = mem[rd_ptr_reg];

        assign rsp_x[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH] = rsp_valid[gi] ? head[DATA_W-1 -: OUTPUT_WIDTH] : '0;
        assign rsp_y[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH] = rsp_valid[gi] ? head[2*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH] : '0;
        assign rsp_z[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH] = rsp_valid[gi] ? head[OUTPUT_WIDTH-1:0] : '0;

        // A credit is a FIFO slot reserved at issue; it comes back only when the slot is popped.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                credit_reg <= CRED_W'(RSP_DEPTH);
            end else if (grant[gi] && !pop) begin
                credit_reg <= credit_reg - 1'b1;
            end else if (pop && !grant[gi]) begin
                credit_reg <= credit_reg + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_reg  <= '0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push && !pop) begin
                    count_reg <= count_reg + 1'b1;
                end else if (pop && !push) begin
                    count_reg <= count_reg - 1'b1;
                end
                if (push) begin
                    wr_ptr_reg <= (wr_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= (rd_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_reg] <= {pipe_out_x, pipe_out_y, pipe_out_z};
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic stall;
    assign stall = (req_valid != '0) && (eligible == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (perf_clr) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (grant_any && (perf_busy != '1)) begin
                perf_busy <= perf_busy + 1'b1;
            end
            if (stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed bench for pipeline_arbiter with an echoing fixed-latency pipeline model and a short
// scoreboarded random phase.
`timescale 1ns/1ps
module tb_pipeline_arbiter;

    localparam int NR = 4;
    localparam int IW = 16;
    localparam int OW = 16;
    localparam int PL = 8;
    localparam int RD = 2;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*IW-1:0] req_x, req_y, req_z;
    logic             pipe_in_valid;
    logic [IW-1:0]    pipe_x, pipe_y, pipe_z;
    logic             pipe_out_valid;
    logic [OW-1:0]    pipe_out_x, pipe_out_y, pipe_out_z;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready;
    logic [NR*OW-1:0] rsp_x, rsp_y, rsp_z;
    logic             tag_err;
    logic             inj;
`ifdef ARB_PERF_CNT_EN
    logic             perf_clr;
    logic [31:0]      perf_busy, perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_arbiter #(
        .NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
        .PIPE_LATENCY(PL), .RSP_DEPTH(RD), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .pipe_in_valid(pipe_in_valid), .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_z(pipe_z),
        .pipe_out_valid(pipe_out_valid), .pipe_out_x(pipe_out_x), .pipe_out_y(pipe_out_y), .pipe_out_z(pipe_out_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .tag_err(tag_err)
`ifdef ARB_PERF_CNT_EN
        , .perf_clr(perf_clr), .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
    );

    // Pipeline model: echoes operands PL cycles later and is never reset, like the real pipe.
    logic [PL-1:0] mv = '0;
    logic [IW-1:0] mx [PL];
    logic [IW-1:0] my [PL];
    logic [IW-1:0] mz [PL];
    always @(posedge clk) begin
        mv    <= {mv[PL-2:0], pipe_in_valid};
        mx[0] <= pipe_x;
        my[0] <= pipe_y;
        mz[0] <= pipe_z;
        for (int s = 1; s < PL; s++) begin
            mx[s] <= mx[s-1];
            my[s] <= my[s-1];
            mz[s] <= mz[s-1];
        end
    end
    assign pipe_out_valid = mv[PL-1] | inj;
    assign pipe_out_x = mx[PL-1];
    assign pipe_out_y = my[PL-1];
    assign pipe_out_z = mz[PL-1];

    always @(negedge clk) begin
        if (!rst && req_ready != '0)
            $display("grant ready=%b x=%h y=%h z=%h", req_ready, req_x, req_y, req_z);
    end

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '1;
        inj = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || pipe_in_valid !== 1'b0 || rsp_valid !== '0 || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b piv=%b rsp_valid=%b tag_err=%b need all 0", req_ready, pipe_in_valid, rsp_valid, tag_err);
        end
        checks++;
        if ({pipe_x, pipe_y, pipe_z} !== '0 || {rsp_x, rsp_y, rsp_z} !== '0) begin
            errors++;
            $display("FAIL reset_data got pipe=%h rsp_x=%h need 0", {pipe_x, pipe_y, pipe_z}, rsp_x);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_priority got %b need 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic test_single_op();
        int n;
        req_x = '0; req_y = '0; req_z = '0;
        req_x[2*IW +: IW] = 16'h0100;
        req_z[2*IW +: IW] = 16'h0080;
        req_valid = 4'b0100;
        rsp_ready = '1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (req_ready !== 4'b0100) begin
                    errors++;
                    $display("FAIL single_ready got %b need 0100", req_ready);
                end
            end
            checks++;
            if (pipe_in_valid !== (c == 1)) begin
                errors++;
                $display("FAIL single_piv cycle %0d got %b need %b", c, pipe_in_valid, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (pipe_x !== 16'h0100 || pipe_y !== 16'h0000 || pipe_z !== 16'h0080) begin
                    errors++;
                    $display("FAIL single_issue got %h %h %h need 0100 0000 0080", pipe_x, pipe_y, pipe_z);
                end
            end
            checks++;
            if (rsp_valid !== ((c == 10) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL single_rsp_valid cycle %0d got %b", c, rsp_valid);
            end
            if (c == 10) begin
                checks++;
                if (rsp_x[2*OW +: OW] !== 16'h0100 || rsp_y[2*OW +: OW] !== 16'h0000 || rsp_z[2*OW +: OW] !== 16'h0080) begin
                    errors++;
                    $display("FAIL single_rsp_data got %h %h %h need 0100 0000 0080",
                             rsp_x[2*OW +: OW], rsp_y[2*OW +: OW], rsp_z[2*OW +: OW]);
                end
            end
            @(posedge clk);
            #1 req_valid = '0;
        end
        // Credit must be back to the full count: exactly RD grants without popping.
        n = 0;
        rsp_ready = '0;
        req_valid = 4'b0100;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (req_ready[2]) n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != RD) begin
            errors++;
            $display("FAIL single_credit_restored got %0d grants need %0d", n, RD);
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_ready;
        logic          prev_grant;
        int            cnt [NR];
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        prev_grant = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        // Each requester's credit returns 11 cycles after its grant: 8 grants then 3 idle per 11 cycles.
        for (int t = 0; t < 64; t++) begin
            exp_ready = ((t % 11) < 8) ? NR'(1 << ((t % 11) % 4)) : '0;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_grant cycle %0d got %b need %b", t, req_ready, exp_ready);
            end
            checks++;
            if (pipe_in_valid !== prev_grant) begin
                errors++;
                $display("FAIL rr_piv cycle %0d got %b need %b", t, pipe_in_valid, prev_grant);
            end
            for (int i = 0; i < NR; i++) if (req_ready[i]) cnt[i]++;
            prev_grant = (req_ready != '0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (cnt[i] != 12) begin
                errors++;
                $display("FAIL rr_fairness req %0d got %0d grants need 12", i, cnt[i]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_credit_backpressure();
        int n;
        int total;
        total = 0;
        req_x = '0; req_y = '0; req_z = '0;
        req_x[1*IW +: IW] = 16'h0A01;
        rsp_ready = '0;
        req_valid = 4'b0010;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin n++; total++; end
            @(posedge clk);
            #1 req_x[1*IW +: IW] = 16'h0A01 + 16'(total);
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL bp_grants got %0d need 2", n);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== 4'b0010 || rsp_x[1*OW +: OW] !== 16'h0A01) begin
            errors++;
            $display("FAIL bp_full got ready=%b rsp_valid=%b head=%h need 0000 0010 0a01", req_ready, rsp_valid, rsp_x[1*OW +: OW]);
        end
        @(posedge clk);
        #1 rsp_ready = 4'b0010;
        @(posedge clk);
        #1 rsp_ready = '0;
        n = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (req_ready[1]) n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL bp_one_more got %0d grants need 1", n);
        end
        req_valid = '0;
        rsp_ready = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (k < 2 && (rsp_valid[1] !== 1'b1 || rsp_x[1*OW +: OW] !== 16'h0A02 + 16'(k))) begin
                errors++;
                $display("FAIL bp_drain pop %0d got valid=%b x=%h need 1 %h", k, rsp_valid[1], rsp_x[1*OW +: OW], 16'h0A02 + 16'(k));
            end else if (k == 2 && rsp_valid[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_drain_empty got valid=%b need 0", rsp_valid[1]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_grant_pop();
        int n;
        req_x = '0; req_y = '0; req_z = '0;
        rsp_ready = '0;
        req_x[0 +: IW] = 16'h00C1;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL gp_first got %b need 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (9) @(posedge clk);
        // Cycle 10: result C1 at the head, credit is 1; grant and pop together.
        #1 req_valid = 4'b0001;
        req_x[0 +: IW] = 16'h00C2;
        rsp_ready = 4'b0001;
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_x[0 +: OW] !== 16'h00C1 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL gp_both got valid=%b x=%h ready=%b need 1 00c1 0001", rsp_valid[0], rsp_x[0 +: OW], req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL gp_popped got valid=%b need 0", rsp_valid[0]);
        end
        @(posedge clk);
        #1 req_valid = 4'b0001;
        req_x[0 +: IW] = 16'h00C3;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[0]) n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL gp_credit_one got %0d grants need 1", n);
        end
        req_valid = '0;
        rsp_ready = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (k < 2 && (rsp_valid[0] !== 1'b1 || rsp_x[0 +: OW] !== 16'h00C2 + 16'(k))) begin
                errors++;
                $display("FAIL gp_occupancy pop %0d got valid=%b x=%h need 1 %h", k, rsp_valid[0], rsp_x[0 +: OW], 16'h00C2 + 16'(k));
            end else if (k == 2 && rsp_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL gp_empty got valid=%b need 0", rsp_valid[0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int            cr [NR];
        logic [47:0]   sb [NR][$];
        logic [47:0]   got;
        logic [NR-1:0] elig;
        for (int i = 0; i < NR; i++) cr[i] = RD;
        for (int t = 0; t < 120; t++) begin
            if (t < 100) begin
                req_valid = NR'($urandom);
                rsp_ready = NR'($urandom);
                req_x = {$urandom, $urandom};
                req_y = {$urandom, $urandom};
                req_z = {$urandom, $urandom};
            end else begin
                req_valid = '0;
                rsp_ready = '1;
            end
            @(negedge clk);
            elig = '0;
            for (int i = 0; i < NR; i++) elig[i] = req_valid[i] && (cr[i] > 0);
            checks++;
            if ((req_ready & ~elig) != '0 || $countones(req_ready) > 1 || (elig != '0 && req_ready == '0)) begin
                errors++;
                $display("FAIL rand_grant cycle %0d got ready=%b eligible=%b", t, req_ready, elig);
            end
            for (int i = 0; i < NR; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    got = {rsp_x[i*OW +: OW], rsp_y[i*OW +: OW], rsp_z[i*OW +: OW]};
                    checks++;
                    if (sb[i].size() == 0) begin
                        errors++;
                        $display("FAIL rand_spurious req %0d got %h need nothing", i, got);
                    end else begin
                        if (got !== sb[i][0]) begin
                            errors++;
                            $display("FAIL rand_data req %0d got %h need %h", i, got, sb[i][0]);
                        end
                        void'(sb[i].pop_front());
                        cr[i]++;
                    end
                end
                if (req_ready[i]) begin
                    sb[i].push_back({req_x[i*IW +: IW], req_y[i*IW +: IW], req_z[i*IW +: IW]});
                    cr[i]--;
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (sb[i].size() != 0) begin
                errors++;
                $display("FAIL rand_lost req %0d got %0d undelivered need 0", i, sb[i].size());
            end
        end
    endtask

    task automatic test_tag_err_and_reset();
        int  n;
        logic seen;
        @(negedge clk);
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL tag_clean got %b need 0", tag_err);
        end
        @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        @(negedge clk);
        checks++;
        if (tag_err !== 1'b1 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL tag_spurious got tag_err=%b rsp_valid=%b need 1 0000", tag_err, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 4'b1000;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL tag_sticky got %b need 1", tag_err);
        end
        @(posedge clk);
        #1 req_valid = '1;
        repeat (5) @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || pipe_in_valid !== 1'b0 || {pipe_x, pipe_y, pipe_z} !== '0 ||
            rsp_valid !== '0 || {rsp_x, rsp_y, rsp_z} !== '0 || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got ready=%b piv=%b pipe_x=%h rsp_valid=%b tag_err=%b need all 0",
                     req_ready, pipe_in_valid, pipe_x, rsp_valid, tag_err);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = '1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (tag_err !== 1'b1 || seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale got tag_err=%b rsp_seen=%b need 1 0", tag_err, seen);
        end
        rsp_ready = '0;
        req_valid = 4'b0001;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (req_ready[0]) n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != RD) begin
            errors++;
            $display("FAIL midreset_credit got %0d grants need %0d", n, RD);
        end
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b0;
        inj = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_x = '0; req_y = '0; req_z = '0;
`ifdef ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        #1 rst = 1'b1;
        test_reset();
        do_reset();
        test_single_op();
        do_reset();
        test_round_robin();
        do_reset();
        test_credit_backpressure();
        do_reset();
        test_grant_pop();
        do_reset();
        test_random();
        do_reset();
        test_tag_err_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
